// File: rtl/fwrisc_regfile_p.sv
// fwrisc_regfile_p: RISC-V GPR file with machine counters, MTVEC and DEP CSRs.
// After reset the GPRs are zeroed one per cycle before the block reports ready.
module fwrisc_regfile_p #(
    parameter int NUM_GPR         = 32,
    parameter int COUNTER_WIDTH   = 64,
    parameter int ENABLE_COUNTERS = 1,
    parameter int ENABLE_DEP      = 1,
    parameter int ENABLE_BYPASS   = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        ready,
    output logic        soft_reset_req,
    input  logic        instr_complete,
    input  logic [5:0]  ra_raddr,
    input  logic [5:0]  rb_raddr,
    output logic [31:0] ra_rdata,
    output logic [31:0] rb_rdata,
    input  logic [5:0]  rd_waddr,
    input  logic [31:0] rd_wdata,
    input  logic        rd_wen,
    output logic [1:0]  counter_ovf,
    output logic        illegal_access,
    output logic [31:0] dep_lo,
    output logic [31:0] dep_hi,
    output logic [31:0] mtvec
);
    localparam int            IW         = $clog2(NUM_GPR);
    localparam logic [5:0]    GPR_LIMIT  = 6'(NUM_GPR);
    localparam logic [IW-1:0] LAST_GPR   = IW'(NUM_GPR - 1);
    localparam logic          HI_WORD_EN = (COUNTER_WIDTH > 32);

    localparam logic [5:0] A_MCYCLE        = 6'h20;
    localparam logic [5:0] A_MCYCLEH       = 6'h21;
    localparam logic [5:0] A_MINSTRET      = 6'h22;
    localparam logic [5:0] A_MINSTRETH     = 6'h23;
    localparam logic [5:0] A_MTVEC         = 6'h28;
    localparam logic [5:0] A_DEP_LO        = 6'h29;
    localparam logic [5:0] A_DEP_HI        = 6'h2A;
    localparam logic [5:0] A_SOFT_RESET    = 6'h2B;
    localparam logic [5:0] A_MCOUNTINHIBIT = 6'h2C;

    typedef enum logic {CLEAR, RUN} state_e;

    state_e                   state_q, state_d;
    logic [IW-1:0]            clrIdx_q, clrIdx_d;
    logic [31:0]              gpr_q [NUM_GPR];
    logic [COUNTER_WIDTH-1:0] cycle_q, cycle_d, instret_q, instret_d;
    logic [1:0]               ovf_q, ovf_d;
    logic [1:0]               inhibit_q, inhibit_d;
    logic [31:0]              mtvec_q, mtvec_d, depLo_q, depLo_d, depHi_q, depHi_d;
    logic [31:0]              raData_q, raData_d, rbData_q, rbData_d;
    logic                     softReset_q, softReset_d, illegal_q, illegal_d;

    logic                     run, gprWe, csrWe, cycleWrSel, instretWrSel;
    logic [63:0]              cycle64, instret64, cycleWr, instretWr;
    logic [COUNTER_WIDTH:0]   cycleInc, instretInc;

    function automatic logic isMapped(input logic [5:0] addr);
        return (addr < GPR_LIMIT) ||
               (addr inside {A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH, A_MTVEC,
                             A_DEP_LO, A_DEP_HI, A_SOFT_RESET, A_MCOUNTINHIBIT});
    endfunction

    assign run   = (state_q == RUN);
    assign gprWe = run && rd_wen && (rd_waddr != 6'd0) && (rd_waddr < GPR_LIMIT);
    assign csrWe = run && rd_wen;

    always_comb begin
        state_d  = state_q;
        clrIdx_d = clrIdx_q;
        unique case (state_q)
            CLEAR: begin
                clrIdx_d = clrIdx_q + IW'(1);
                if (clrIdx_q == LAST_GPR) begin
                    state_d  = RUN;
                    clrIdx_d = '0;
                end
            end
            RUN: begin
            end
        endcase
    end

    // Counters are handled as 64-bit images so the high word works for any width.
    assign cycle64    = 64'(cycle_q);
    assign instret64  = 64'(instret_q);
    assign cycleWr    = rd_waddr[0] ? {rd_wdata, cycle64[31:0]}   : {cycle64[63:32], rd_wdata};
    assign instretWr  = rd_waddr[0] ? {rd_wdata, instret64[31:0]} : {instret64[63:32], rd_wdata};
    assign cycleInc   = {1'b0, cycle_q}   + {{COUNTER_WIDTH{1'b0}}, 1'b1};
    assign instretInc = {1'b0, instret_q} + {{COUNTER_WIDTH{1'b0}}, 1'b1};
    assign cycleWrSel   = csrWe && ((rd_waddr == A_MCYCLE) || (HI_WORD_EN && (rd_waddr == A_MCYCLEH)));
    assign instretWrSel = csrWe && ((rd_waddr == A_MINSTRET) || (HI_WORD_EN && (rd_waddr == A_MINSTRETH)));

    always_comb begin
        cycle_d   = cycle_q;
        instret_d = instret_q;
        ovf_d     = ovf_q;
        if (cycleWrSel) begin
            cycle_d  = cycleWr[COUNTER_WIDTH-1:0];
            ovf_d[0] = 1'b0;
        end else if (run && !inhibit_q[0]) begin
            cycle_d = cycleInc[COUNTER_WIDTH-1:0];
            if (cycleInc[COUNTER_WIDTH]) ovf_d[0] = 1'b1;
        end
        if (instretWrSel) begin
            instret_d = instretWr[COUNTER_WIDTH-1:0];
            ovf_d[1]  = 1'b0;
        end else if (run && instr_complete && !inhibit_q[1]) begin
            instret_d = instretInc[COUNTER_WIDTH-1:0];
            if (instretInc[COUNTER_WIDTH]) ovf_d[1] = 1'b1;
        end
        if (ENABLE_COUNTERS == 0) begin
            cycle_d   = '0;
            instret_d = '0;
            ovf_d     = '0;
        end
    end

    // inhibit_q holds MCOUNTINHIBIT bits {2, 0}; a DEP register freezes once its bit1 is set.
    always_comb begin
        inhibit_d = inhibit_q;
        mtvec_d   = mtvec_q;
        depLo_d   = depLo_q;
        depHi_d   = depHi_q;
        if (csrWe) begin
            case (rd_waddr)
                A_MTVEC:         mtvec_d = rd_wdata;
                A_DEP_LO:        if (!depLo_q[1]) depLo_d = rd_wdata;
                A_DEP_HI:        if (!depHi_q[1]) depHi_d = rd_wdata;
                A_MCOUNTINHIBIT: inhibit_d = {rd_wdata[2], rd_wdata[0]};
                default: begin
                end
            endcase
        end
        if (ENABLE_DEP == 0) begin
            depLo_d = '0;
            depHi_d = '0;
        end
        softReset_d = csrWe && (rd_waddr == A_SOFT_RESET);
        illegal_d   = run && (!isMapped(ra_raddr) || !isMapped(rb_raddr) ||
                              (rd_wen && !isMapped(rd_waddr)));
    end

    always_comb begin
        raData_d = '0;
        rbData_d = '0;
        if (run) begin
            if ((ENABLE_BYPASS != 0) && gprWe && (rd_waddr == ra_raddr))
                raData_d = rd_wdata;
            else if ((ra_raddr != 6'd0) && (ra_raddr < GPR_LIMIT))
                raData_d = gpr_q[ra_raddr[IW-1:0]];

            if ((ENABLE_BYPASS != 0) && gprWe && (rd_waddr == rb_raddr))
                rbData_d = rd_wdata;
            else if ((rb_raddr != 6'd0) && (rb_raddr < GPR_LIMIT))
                rbData_d = gpr_q[rb_raddr[IW-1:0]];
            else begin
                case (rb_raddr)
                    A_MCYCLE:        rbData_d = cycle64[31:0];
                    A_MCYCLEH:       rbData_d = cycle64[63:32];
                    A_MINSTRET:      rbData_d = instret64[31:0];
                    A_MINSTRETH:     rbData_d = instret64[63:32];
                    A_MTVEC:         rbData_d = mtvec_q;
                    A_DEP_LO:        rbData_d = depLo_q;
                    A_DEP_HI:        rbData_d = depHi_q;
                    A_MCOUNTINHIBIT: rbData_d = {29'd0, inhibit_q[1], 1'b0, inhibit_q[0]};
                    default:         rbData_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= CLEAR;
            clrIdx_q    <= '0;
            cycle_q     <= '0;
            instret_q   <= '0;
            ovf_q       <= '0;
            inhibit_q   <= '0;
            mtvec_q     <= '0;
            depLo_q     <= '0;
            depHi_q     <= '0;
            raData_q    <= '0;
            rbData_q    <= '0;
            softReset_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clrIdx_q    <= clrIdx_d;
            cycle_q     <= cycle_d;
            instret_q   <= instret_d;
            ovf_q       <= ovf_d;
            inhibit_q   <= inhibit_d;
            mtvec_q     <= mtvec_d;
            depLo_q     <= depLo_d;
            depHi_q     <= depHi_d;
            raData_q    <= raData_d;
            rbData_q    <= rbData_d;
            softReset_q <= softReset_d;
            illegal_q   <= illegal_d;
        end
    end

    // GPR storage has no reset of its own; the CLEAR sweep zeroes it.
    always_ff @(posedge clock) begin
        if (state_q == CLEAR)
            gpr_q[clrIdx_q] <= '0;
        else if (gprWe)
            gpr_q[rd_waddr[IW-1:0]] <= rd_wdata;
    end

    assign ready          = (state_q == RUN);
    assign soft_reset_req = softReset_q;
    assign ra_rdata       = raData_q;
    assign rb_rdata       = rbData_q;
    assign counter_ovf    = ovf_q;
    assign illegal_access = illegal_q;
    assign dep_lo         = depLo_q;
    assign dep_hi         = depHi_q;
    assign mtvec          = mtvec_q;
endmodule
